// File: rtl/stuff_tx.sv
// stuff_tx: serial bit-stuffing transmitter, MSB first.
// Inserts a complement bit after MAX_RUN equal bits.
//
// Ports:
//   clk        rising-edge clock
//   reset      async active-low reset
//   din        word to transmit (DATA_W bits)
//   din_valid  producer has a word on din
//   din_ready  word accepted on din_valid && din_ready
//   tx_bit     serial bit (1 when tx_valid=0)
//   tx_valid   tx_bit carries a data or stuff bit
//   busy       state is not IDLE
//   stuff_cnt  saturating stuff-bit count
//              (only with STUFF_STATS_EN defined)
module stuff_tx #(
    parameter int DATA_W  = 8,
    parameter int MAX_RUN = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic              tx_bit,
    output logic              tx_valid,
    output logic              busy
`ifdef STUFF_STATS_EN
    ,
    output logic [15:0]       stuff_cnt
`endif
);

    localparam int BW = $clog2(DATA_W);
    localparam int RW = $clog2(MAX_RUN + 1);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        STUFF
    } state_t;

    state_t            state, state_n;
    logic [DATA_W-1:0] sh, sh_n;
    logic [BW-1:0]     bcnt, bcnt_n;
    logic [RW-1:0]     run, run_n;
    logic [RW-1:0]     newrun;
    logic              last_bit, last_bit_n;
    logic              b;
    logic              done;

    always_comb begin
        b          = sh[DATA_W-1];
        // run==0 means no bit since idle: start a fresh run
        newrun     = (run != '0 && b == last_bit)
                   ? run + RW'(1) : RW'(1);
        state_n    = state;
        sh_n       = sh;
        bcnt_n     = bcnt;
        run_n      = run;
        last_bit_n = last_bit;
        done       = 1'b0;
        din_ready  = 1'b0;

        unique case (state)
            IDLE: begin
                din_ready = 1'b1;
                run_n     = '0;
                if (din_valid) begin
                    sh_n    = din;
                    bcnt_n  = BW'(DATA_W - 1);
                    state_n = DATA;
                end
            end
            DATA: begin
                last_bit_n = b;
                run_n      = newrun;
                sh_n       = {sh[DATA_W-2:0], 1'b0};
                // stuff takes priority even on the last data bit
                if (newrun == RW'(MAX_RUN)) begin
                    state_n = STUFF;
                end else if (bcnt != '0) begin
                    bcnt_n = bcnt - BW'(1);
                end else begin
                    done = 1'b1;
                end
            end
            STUFF: begin
                last_bit_n = ~last_bit;
                run_n      = RW'(1);
                if (bcnt != '0) begin
                    bcnt_n  = bcnt - BW'(1);
                    state_n = DATA;
                end else begin
                    done = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // word complete: chain the next word with no gap,
        // otherwise drop to idle and forget the run
        if (done) begin
            din_ready = 1'b1;
            if (din_valid) begin
                sh_n    = din;
                bcnt_n  = BW'(DATA_W - 1);
                state_n = DATA;
            end else begin
                state_n = IDLE;
                run_n   = '0;
            end
        end
    end

    always_comb begin
        tx_bit   = 1'b1;
        tx_valid = 1'b0;
        unique case (state)
            DATA: begin
                tx_bit   = sh[DATA_W-1];
                tx_valid = 1'b1;
            end
            STUFF: begin
                tx_bit   = ~last_bit;
                tx_valid = 1'b1;
            end
            default: begin
                tx_bit   = 1'b1;
                tx_valid = 1'b0;
            end
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            sh       <= '0;
            bcnt     <= '0;
            run      <= '0;
            last_bit <= 1'b1;
        end else begin
            state    <= state_n;
            sh       <= sh_n;
            bcnt     <= bcnt_n;
            run      <= run_n;
            last_bit <= last_bit_n;
        end
    end

`ifdef STUFF_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stuff_cnt <= '0;
        end else if (state == STUFF && stuff_cnt != 16'hFFFF) begin
            stuff_cnt <= stuff_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_stuff_tx.sv
// tb_stuff_tx: directed checks on a default stuff_tx and a
// randomized queue-model check on a MAX_RUN=2 instance.
module tb_stuff_tx;

    localparam int MR2 = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] din = '0;
    logic       din_valid = 1'b0;
    logic       din_ready, tx_bit, tx_valid, busy;
    logic [7:0] din2 = '0;
    logic       din_valid2 = 1'b0;
    logic       din_ready2, tx_bit2, tx_valid2, busy2;
`ifdef STUFF_STATS_EN
    logic [15:0] stuff_cnt, stuff_cnt2;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    stuff_tx u_dut (
        .clk       (clk),
        .reset     (reset),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .tx_bit    (tx_bit),
        .tx_valid  (tx_valid),
        .busy      (busy)
`ifdef STUFF_STATS_EN
        ,
        .stuff_cnt (stuff_cnt)
`endif
    );

    stuff_tx #(.DATA_W(8), .MAX_RUN(MR2)) u_dut2 (
        .clk       (clk),
        .reset     (reset),
        .din       (din2),
        .din_valid (din_valid2),
        .din_ready (din_ready2),
        .tx_bit    (tx_bit2),
        .tx_valid  (tx_valid2),
        .busy      (busy2)
`ifdef STUFF_STATS_EN
        ,
        .stuff_cnt (stuff_cnt2)
`endif
    );

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h @%0t",
                     tag, got, exp, $time);
        end
    endtask

    // one isolated word, expected bits given MSB-first in exp[n-1:0]
    task automatic send_one(input logic [7:0] w,
                            input logic [31:0] exp,
                            input int n,
                            input string tag);
        @(negedge clk);
        din       = w;
        din_valid = 1'b1;
        check({tag, "_rdy0"}, 32'(din_ready), 32'd1);
        check({tag, "_busy0"}, 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        din       = 8'($urandom);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check({tag, "_vld"}, 32'(tx_valid), 32'd1);
            check({tag, "_bit"}, 32'(tx_bit), 32'(exp[n-1-i]));
            check({tag, "_rdy"}, 32'(din_ready), 32'(i == n - 1));
            check({tag, "_busy"}, 32'(busy), 32'd1);
        end
        @(negedge clk);
        check({tag, "_endvld"}, 32'(tx_valid), 32'd0);
        check({tag, "_endbit"}, 32'(tx_bit), 32'd1);
        check({tag, "_endbusy"}, 32'(busy), 32'd0);
    endtask

    // reference model for the MAX_RUN=2 instance: expected line bits
    bit q[$];
    int mrun  = 0;
    bit mlast = 1'b1;
    int nstuff = 0;

    task automatic model_add(input logic [7:0] w);
        bit bb;
        for (int i = 7; i >= 0; i--) begin
            bb = w[i];
            if (mrun > 0 && bb == mlast) mrun++;
            else mrun = 1;
            mlast = bb;
            q.push_back(bb);
            if (mrun == MR2) begin
                q.push_back(!bb);
                mlast = !bb;
                mrun  = 1;
                nstuff++;
            end
        end
    endtask

    initial begin
        logic [31:0] b2b;
        logic [31:0] a5;
        int   acc;
        int   dcnt;
        bit   dlast;
        bit   took;
        bit   eb;
        bit   ev;

        // reset state
        @(negedge clk);
        check("rst_vld", 32'(tx_valid), 32'd0);
        check("rst_bit", 32'(tx_bit), 32'd1);
        check("rst_rdy", 32'(din_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        send_one(8'h55, 32'h55, 8, "w55");
        send_one(8'hFF, 32'b111110111, 9, "wFF");
        // run must not carry over the idle gap
        send_one(8'hF0, 32'hF0, 8, "wF0");
        send_one(8'h1F, 32'b000111110, 9, "w1F");

        // back-to-back FF,FF
        b2b = 32'b111110111_1101111101;
        @(negedge clk);
        din       = 8'hFF;
        din_valid = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            check("b2b_vld", 32'(tx_valid), 32'd1);
            check("b2b_bit", 32'(tx_bit), 32'(b2b[18-i]));
            check("b2b_rdy", 32'(din_ready),
                  32'(i == 8 || i == 18));
            if (i == 8) begin
                @(posedge clk);
                #1;
                din_valid = 1'b0;
            end
        end
        @(negedge clk);
        check("b2b_end", 32'(tx_valid), 32'd0);
        check("b2b_busy", 32'(busy), 32'd0);
`ifdef STUFF_STATS_EN
        check("cnt_pre", 32'(stuff_cnt), 32'd5);
`endif

        // reset in the middle of A5
        a5 = 32'hA5;
        @(negedge clk);
        din       = 8'hA5;
        din_valid = 1'b1;
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("a5_bit", 32'(tx_bit), 32'(a5[7-i]));
        end
        reset = 1'b0;
        #1;
        check("arst_vld", 32'(tx_valid), 32'd0);
        check("arst_bit", 32'(tx_bit), 32'd1);
        check("arst_rdy", 32'(din_ready), 32'd1);
        check("arst_busy", 32'(busy), 32'd0);
`ifdef STUFF_STATS_EN
        check("cnt_rst", 32'(stuff_cnt), 32'd0);
`endif
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("post_vld", 32'(tx_valid), 32'd0);
        send_one(8'h00, 32'b000001000, 9, "w00");
`ifdef STUFF_STATS_EN
        check("cnt_end", 32'(stuff_cnt), 32'd1);
`endif

        // randomized traffic on the MAX_RUN=2 instance
        acc  = 0;
        dcnt = 0;
        dlast = 1'b1;
        @(posedge clk);
        #1;
        din2       = 8'($urandom);
        din_valid2 = 1'b1;
        for (int cyc = 0; cyc < 40000; cyc++) begin
            @(negedge clk);
            ev = (q.size() != 0);
            check("rnd_rdy", 32'(din_ready2), 32'(q.size() <= 1));
            check("rnd_vld", 32'(tx_valid2), 32'(ev));
            check("rnd_busy", 32'(busy2), 32'(ev));
            if (ev) begin
                eb = q.pop_front();
                check("rnd_bit", 32'(tx_bit2), 32'(eb));
            end else begin
                check("rnd_idlebit", 32'(tx_bit2), 32'd1);
                mrun = 0;
            end
            if (tx_valid2) begin
                if (dcnt > 0 && tx_bit2 == dlast) dcnt++;
                else dcnt = 1;
                dlast = tx_bit2;
                check("det3", 32'(dcnt >= 3), 32'd0);
            end else begin
                dcnt = 0;
            end
            took = 1'b0;
            if (din_valid2 && din_ready2) begin
                model_add(din2);
                acc++;
                took = 1'b1;
            end
            if (acc >= 1000 && q.size() == 0 && !din_valid2)
                break;
            @(posedge clk);
            #1;
            if (took || !din_valid2) begin
                din2       = 8'($urandom);
                din_valid2 = (acc < 1000) &&
                             ($urandom_range(0, 9) != 0);
            end
        end
        check("rnd_done", 32'(acc == 1000 && q.size() == 0), 32'd1);
`ifdef STUFF_STATS_EN
        check("cnt2", 32'(stuff_cnt2), 32'(nstuff));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
